// File: rtl/mbus_tx_arbiter_pkg.sv
// Shared types and helpers for the MBus transmit arbiter and related ring arbiters.
//   arb_state_e : arbiter FSM state encoding
//   arb_res_e   : transfer outcome reported to the owner
//   f_log2      : number of bits needed to hold a value (minimum 1)
//   f_max       : larger of two unsigned values
package mbus_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE      = 3'd0,
        ARB_REQUEST   = 3'd1,
        ARB_WAIT_DONE = 3'd2,
        ARB_BACKOFF   = 3'd3,
        ARB_REPORT    = 3'd4
    } arb_state_e;

    typedef enum logic {
        RES_SUCC = 1'b0,
        RES_FAIL = 1'b1
    } arb_res_e;

    // Width of a counter/index that must represent 'value' itself.
    function automatic int unsigned f_log2(input int unsigned value);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((value >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic int unsigned f_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mbus_rr_pick.sv
// Rotating-priority encoder: returns the first set request bit at or above
// i_ptr, wrapping modulo NUM_REQ. Purely combinational.
//   i_req   : request vector
//   i_ptr   : highest-priority index this round
//   o_valid : at least one request set
//   o_idx   : winning index (0 when o_valid is low)
module mbus_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    // Index 'off' positions above 'base', wrapped into 0..NUM_REQ-1.
    function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base,
                                               input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!o_valid && i_req[f_wrap(i_ptr, k)]) begin
                o_valid = 1'b1;
                o_idx   = f_wrap(i_ptr, k);
            end
        end
    end

endmodule

// File: rtl/mbus_tx_arbiter.sv
// MBus transmit-path arbiter: shares one transmit engine among NUM_REQ local
// requesters with round-robin grant, bounded retry with backoff after bus
// errors, and a one-cycle DONE/FAIL report to the owner.
// Optional feature macro: MBUS_TX_ARB_WATCHDOG_EN (WAIT_DONE timeout -> FAIL).
//   CLK_IN  : clock, rising edge
//   RESET   : synchronous active-high reset
//   REQ     : per-requester level request
//   GNT     : one-hot owner indication
//   DONE    : one-cycle success pulse to owner
//   FAIL    : one-cycle failure pulse to owner
//   TX_REQ  : level request to the transmit engine
//   TX_SEL  : owner index
//   TX_ACK  : transmitter accepted the request (pulse)
//   TX_SUCC : transfer acknowledged on the bus (pulse)
//   TX_ERR  : arbitration lost / NAK / bus reset (pulse)
//   BUSY    : arbiter not idle
module mbus_tx_arbiter
    import mbus_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned BACKOFF_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                             CLK_IN,
    input  logic                             RESET,
    input  logic [NUM_REQ-1:0]               REQ,
    output logic [NUM_REQ-1:0]               GNT,
    output logic [NUM_REQ-1:0]               DONE,
    output logic [NUM_REQ-1:0]               FAIL,
    output logic                             TX_REQ,
    output logic [f_log2(NUM_REQ-1)-1:0]     TX_SEL,
    input  logic                             TX_ACK,
    input  logic                             TX_SUCC,
    input  logic                             TX_ERR,
    output logic                             BUSY
);

    localparam int unsigned IDX_W   = f_log2(NUM_REQ - 1);
    localparam int unsigned RETRY_W = f_log2(MAX_RETRY);
    localparam int unsigned CNT_W   = f_log2(f_max(BACKOFF_CYCLES, TIMEOUT_CYCLES) - 1);

    arb_state_e           r_state;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_owner;
    logic [RETRY_W-1:0]   r_retry;
    logic [CNT_W-1:0]     r_backoff;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic [NUM_REQ-1:0]   r_fail;
    logic                 r_tx_req;
    logic                 r_busy;
`ifdef MBUS_TX_ARB_WATCHDOG_EN
    logic [CNT_W-1:0]     r_wdog;
`endif

    logic                 w_pick_valid;
    logic [IDX_W-1:0]     w_pick_idx;
    logic [IDX_W-1:0]     w_owner_nxt;
    logic                 w_wait_end;
    arb_res_e             w_wait_res;
    logic                 w_retry;

    mbus_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req   (REQ),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Round-robin pointer moves one past the outgoing owner.
    assign w_owner_nxt = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

    // WAIT_DONE outcome; an error outranks a simultaneous success, and real
    // bus events outrank a watchdog expiry in the same cycle.
    always_comb begin
        w_wait_end = 1'b0;
        w_wait_res = RES_SUCC;
        w_retry    = 1'b0;
        if (TX_ERR) begin
            if (r_retry < RETRY_W'(MAX_RETRY)) begin
                w_retry = 1'b1;
            end else begin
                w_wait_end = 1'b1;
                w_wait_res = RES_FAIL;
            end
        end else if (TX_SUCC) begin
            w_wait_end = 1'b1;
        end
`ifdef MBUS_TX_ARB_WATCHDOG_EN
        else if (r_wdog == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            w_wait_end = 1'b1;
            w_wait_res = RES_FAIL;
        end
`endif
    end

    // Arbiter FSM with registered outputs.
    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            r_state   <= ARB_IDLE;
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_retry   <= '0;
            r_backoff <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_fail    <= '0;
            r_tx_req  <= 1'b0;
            r_busy    <= 1'b0;
`ifdef MBUS_TX_ARB_WATCHDOG_EN
            r_wdog    <= '0;
`endif
        end else begin
            r_done <= '0;
            r_fail <= '0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_owner  <= w_pick_idx;
                        r_gnt    <= NUM_REQ'(1) << w_pick_idx;
                        r_tx_req <= 1'b1;
                        r_retry  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ARB_REQUEST;
                    end
                end

                ARB_REQUEST: begin
                    // An accept in the same cycle as a dropped request still wins.
                    if (TX_ACK) begin
                        r_tx_req <= 1'b0;
                        r_state  <= ARB_WAIT_DONE;
`ifdef MBUS_TX_ARB_WATCHDOG_EN
                        r_wdog   <= '0;
`endif
                    end else if (!REQ[r_owner]) begin
                        r_tx_req <= 1'b0;
                        r_gnt    <= '0;
                        r_rr_ptr <= w_owner_nxt;
                        r_busy   <= 1'b0;
                        r_state  <= ARB_IDLE;
                    end
                end

                ARB_WAIT_DONE: begin
                    if (w_wait_end) begin
                        if (w_wait_res == RES_SUCC) begin
                            r_done <= r_gnt;
                        end else begin
                            r_fail <= r_gnt;
                        end
                        r_state <= ARB_REPORT;
                    end else if (w_retry) begin
                        r_retry   <= r_retry + RETRY_W'(1);
                        r_backoff <= CNT_W'(BACKOFF_CYCLES - 1);
                        r_state   <= ARB_BACKOFF;
                    end
`ifdef MBUS_TX_ARB_WATCHDOG_EN
                    else begin
                        r_wdog <= r_wdog + CNT_W'(1);
                    end
`endif
                end

                ARB_BACKOFF: begin
                    if (r_backoff == '0) begin
                        r_tx_req <= 1'b1;
                        r_state  <= ARB_REQUEST;
                    end else begin
                        r_backoff <= r_backoff - CNT_W'(1);
                    end
                end

                ARB_REPORT: begin
                    r_gnt    <= '0;
                    r_rr_ptr <= w_owner_nxt;
                    r_busy   <= 1'b0;
                    r_state  <= ARB_IDLE;
                end

                default: begin
                    r_gnt    <= '0;
                    r_tx_req <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ARB_IDLE;
                end
            endcase
        end
    end

    assign GNT    = r_gnt;
    assign DONE   = r_done;
    assign FAIL   = r_fail;
    assign TX_REQ = r_tx_req;
    assign TX_SEL = r_owner;
    assign BUSY   = r_busy;

endmodule

// File: tb/tb_mbus_tx_arbiter.sv
// Directed self-checking bench for mbus_tx_arbiter (NUM_REQ=4, MAX_RETRY=3,
// BACKOFF_CYCLES=16, TIMEOUT_CYCLES=8).
module tb_mbus_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] done;
    logic [3:0] fail;
    logic       tx_req;
    logic [1:0] tx_sel;
    logic       tx_ack;
    logic       tx_succ;
    logic       tx_err;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mbus_tx_arbiter #(
        .NUM_REQ        (4),
        .MAX_RETRY      (3),
        .BACKOFF_CYCLES (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK_IN  (clk),
        .RESET   (rst),
        .REQ     (req),
        .GNT     (gnt),
        .DONE    (done),
        .FAIL    (fail),
        .TX_REQ  (tx_req),
        .TX_SEL  (tx_sel),
        .TX_ACK  (tx_ack),
        .TX_SUCC (tx_succ),
        .TX_ERR  (tx_err),
        .BUSY    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        tx_ack = 1'b1; step(); tx_ack = 1'b0;
    endtask

    task automatic pulse_succ();
        tx_succ = 1'b1; step(); tx_succ = 1'b0;
    endtask

    task automatic pulse_err(input logic with_succ);
        tx_err = 1'b1; tx_succ = with_succ; step(); tx_err = 1'b0; tx_succ = 1'b0;
    endtask

    // Cycles until TX_REQ rises, bounded.
    task automatic wait_txreq(output int n);
        n = 0;
        while (tx_req !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        int order [5];
        int n;
        logic [3:0] exp_nxt;
        order = '{0, 1, 2, 3, 0};

        rst = 1'b1; req = '0; tx_ack = 1'b0; tx_succ = 1'b0; tx_err = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_gnt",    32'(gnt),    32'h0);
        chk("rst_txreq",  32'(tx_req), 32'h0);
        chk("rst_busy",   32'(busy),   32'h0);
        chk("rst_done",   32'(done),   32'h0);
        chk("rst_fail",   32'(fail),   32'h0);
        chk("rst_txsel",  32'(tx_sel), 32'h0);

        // 1: basic grant, success, round-robin advance
        req = 4'b1010;
        step();
        chk("t1_gnt",   32'(gnt),    32'h2);
        chk("t1_txsel", 32'(tx_sel), 32'h1);
        chk("t1_txreq", 32'(tx_req), 32'h1);
        chk("t1_busy",  32'(busy),   32'h1);
        pulse_ack();
        chk("t1_txreq_ack", 32'(tx_req), 32'h0);
        chk("t1_gnt_wait",  32'(gnt),    32'h2);
        pulse_succ();
        chk("t1_done",     32'(done), 32'h2);
        chk("t1_gnt_rep",  32'(gnt),  32'h2);
        chk("t1_fail",     32'(fail), 32'h0);
        step();
        chk("t1_done_clr", 32'(done), 32'h0);
        chk("t1_gnt_idle", 32'(gnt),  32'h0);
        chk("t1_busy_idle", 32'(busy), 32'h0);
        step();
        chk("t1_gnt_next",   32'(gnt),    32'h8);
        chk("t1_txsel_next", 32'(tx_sel), 32'h3);
        pulse_ack();
        pulse_succ();
        chk("t1_done3", 32'(done), 32'h8);
        req = 4'b0000;
        step();
        step();
        chk("t1_quiet", 32'(gnt), 32'h0);

        // 2: all requesting, rotation order and 3-cycle turnaround
        req = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t2_gnt",   32'(gnt),    32'(4'b0001 << order[i]));
            chk("t2_txsel", 32'(tx_sel), 32'(order[i]));
            pulse_ack();
            pulse_succ();
            chk("t2_done", 32'(done), 32'(4'b0001 << order[i]));
            if (i == 4) req = 4'b0000;
            exp_nxt = (i < 4) ? (4'b0001 << order[i + 1]) : 4'b0000;
            step();
            chk("t2_gap_idle", 32'(gnt), 32'h0);
            step();
            chk("t2_gnt_after_gap", 32'(gnt), 32'(exp_nxt));
        end

        // 3: three errors then success
        req = 4'b0100;
        step();
        chk("t3_gnt", 32'(gnt), 32'h4);
        pulse_ack();
        for (int r = 0; r < 3; r++) begin
            pulse_err(1'b0);
            chk("t3_txreq_low", 32'(tx_req), 32'h0);
            chk("t3_gnt_hold",  32'(gnt),    32'h4);
            wait_txreq(n);
            chk("t3_backoff_len", 32'(n),   32'd16);
            chk("t3_gnt_rereq",   32'(gnt), 32'h4);
            pulse_ack();
        end
        pulse_succ();
        chk("t3_done", 32'(done), 32'h4);
        chk("t3_fail", 32'(fail), 32'h0);
        req = 4'b0000;
        step();

        // 4: retry exhaustion; second error arrives together with TX_SUCC
        req = 4'b0100;
        step();
        chk("t4_gnt", 32'(gnt), 32'h4);
        pulse_ack();
        for (int r = 0; r < 3; r++) begin
            pulse_err(r == 1);
            chk("t4_no_done", 32'(done), 32'h0);
            wait_txreq(n);
            chk("t4_backoff_len", 32'(n), 32'd16);
            pulse_ack();
        end
        pulse_err(1'b0);
        chk("t4_fail", 32'(fail), 32'h4);
        chk("t4_done", 32'(done), 32'h0);
        req = 4'b0000;
        step();
        chk("t4_fail_clr", 32'(fail), 32'h0);
        chk("t4_gnt_clr",  32'(gnt),  32'h0);

        // 5: abort before accept, then reset during WAIT_DONE
        req = 4'b0010;
        step();
        chk("t5_gnt",   32'(gnt),    32'h2);
        chk("t5_txreq", 32'(tx_req), 32'h1);
        req = 4'b0000;
        step();
        chk("t5_abort_gnt",   32'(gnt),    32'h0);
        chk("t5_abort_txreq", 32'(tx_req), 32'h0);
        chk("t5_abort_done",  32'(done),   32'h0);
        chk("t5_abort_fail",  32'(fail),   32'h0);
        chk("t5_abort_busy",  32'(busy),   32'h0);
        req = 4'b0110;
        step();
        chk("t5_ptr_after_abort", 32'(gnt), 32'h4);
        pulse_ack();
        rst = 1'b1;
        step();
        chk("t5_rst_gnt",   32'(gnt),    32'h0);
        chk("t5_rst_txreq", 32'(tx_req), 32'h0);
        chk("t5_rst_done",  32'(done),   32'h0);
        chk("t5_rst_fail",  32'(fail),   32'h0);
        chk("t5_rst_busy",  32'(busy),   32'h0);
        rst = 1'b0;
        step();
        chk("t5_ptr_reset", 32'(gnt),  32'h2);
        chk("t5_no_pulse",  32'(done | fail), 32'h0);
        req = 4'b0000;
        step();
        chk("t5_abort2_gnt", 32'(gnt), 32'h0);

        // 6: silent transmitter after accept
        req = 4'b0001;
        step();
        chk("t6_gnt", 32'(gnt), 32'h1);
        pulse_ack();
`ifdef MBUS_TX_ARB_WATCHDOG_EN
        n = 0;
        while (fail !== 4'b0001 && n < 50) begin
            step();
            n++;
        end
        chk("t6_wdog_fail", 32'(fail),   32'h1);
        chk("t6_wdog_len",  32'(n),      32'd8);
        chk("t6_wdog_done", 32'(done),   32'h0);
        step();
        chk("t6_no_retry",  32'(tx_req), 32'h0);
`else
        repeat (2000) step();
        chk("t6_gnt_held", 32'(gnt),    32'h1);
        chk("t6_busy",     32'(busy),   32'h1);
        chk("t6_no_fail",  32'(fail),   32'h0);
        chk("t6_txreq",    32'(tx_req), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
